regfile_wb_arbiter: RTL

//  Shares the single write port of the 16x32 register file among NREQ writeback

---
 rtl/rf_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and FSM encoding for the register-file writeback arbiter.
// The optional RF_WB_STALL_CNT_EN build of the top adds per-requester stall counters.
package rf_pkg;

    localparam int RF_AW = 4;
    localparam int RF_DW = 32;

    localparam logic [RF_AW-1:0] RF_ZERO_REG  = 4'd0;
    localparam logic [RF_AW-1:0] RF_ONE_REG   = 4'd15;
    localparam logic [RF_AW-1:0] RF_CLR_FIRST = 4'd1;
    localparam logic [RF_AW-1:0] RF_CLR_LAST  = 4'd14;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first valid requester found searching
// from ptr upward (mod NREQ) gets the one-hot grant.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   gnt_idx,
    output logic            gnt_any
);

    logic [PW-1:0] cand;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!gnt_any && valid[cand]) begin
                gnt_any       = 1'b1;
                grant[cand]   = 1'b1;
                gnt_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters after a
// post-reset clear of r1..r14. Define RF_WB_STALL_CNT_EN to add stall counters.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [AW-1:0]    rf_wp,
    output logic [DW-1:0]    rf_din,
    output logic             rf_we,
    output logic             rf_rst,
    output logic             init_done
`ifdef RF_WB_STALL_CNT_EN
    ,
    output logic [NREQ*16-1:0] stall_cnt
`endif
);

    localparam int PW = $clog2(NREQ);

    wb_state_t     state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_wp_q, rf_wp_d;
    logic [DW-1:0] rf_din_q, rf_din_d;
    logic          init_done_q, init_done_d;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            xfer;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .valid   (req_valid),
        .ptr     (rr_ptr_q),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        rr_ptr_d    = rr_ptr_q;
        rf_we_d     = 1'b0;
        rf_wp_d     = rf_wp_q;
        rf_din_d    = rf_din_q;
        init_done_d = (state_q == RUN);
        req_ready   = '0;
        xfer        = 1'b0;
        case (state_q)
            CLEAR: begin
                rf_we_d  = 1'b1;
                rf_wp_d  = clr_addr_q;
                rf_din_d = '0;
                if (clr_addr_q == RF_CLR_LAST) begin
                    state_d = RUN;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            RUN: begin
                if (!hold) begin
                    req_ready = grant;
                    xfer      = gnt_any;
                end
                if (xfer) begin
                    rr_ptr_d = PW'((int'(gnt_idx) + 1) % NREQ);
                    // r0 and r15 are constants: consume the request, drop the write.
                    if (sel_addr != RF_ZERO_REG && sel_addr != RF_ONE_REG) begin
                        rf_we_d  = 1'b1;
                        rf_wp_d  = sel_addr;
                        rf_din_d = sel_data;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_addr_q  <= RF_CLR_FIRST;
            rr_ptr_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_wp_q     <= '0;
            rf_din_q    <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            rr_ptr_q    <= rr_ptr_d;
            rf_we_q     <= rf_we_d;
            rf_wp_q     <= rf_wp_d;
            rf_din_q    <= rf_din_d;
            init_done_q <= init_done_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_wp     = rf_wp_q;
    assign rf_din    = rf_din_q;
    assign rf_rst    = 1'b0;
    assign init_done = init_done_q;

`ifdef RF_WB_STALL_CNT_EN
    logic [NREQ*16-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < NREQ; i++) begin
            if (state_q == RUN && req_valid[i] && !req_ready[i] &&
                stall_cnt_q[i*16 +: 16] != 16'hFFFF) begin
                stall_cnt_d[i*16 +: 16] = stall_cnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
